multiword_add_sequencer: RTL and testbench
==========================================

# multiword_add_sequencer

Streams multi-word (multi-limb) add/subtract operations through a single 32-bit adder datapath, one limb per cycle, least-significant limb first. It sits directly upstream of and wraps the 32-bit word adder: it accepts operand limbs over a valid/ready handshake, drives the adder's operands and carry-in, and registers the adder's sum and carry-out. The carry is chained across limbs in a register. Result limbs leave on a registered valid/ready output with final carry and overflow flags.

## Interface
- `WORD_W`, 32: limb width; fixed at 32 and checked at elaboration.
- `IDX_W`, 4: width of the limb index counter.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: an input limb is presented.
- `in_ready` out 1: the block accepts the limb this cycle.
- `in_a` in 32: operand A limb.
- `in_b` in 32: operand B limb.
- `in_sub` in 1: subtract (A−B); sampled only on the first limb of an operation.
- `in_last` in 1: most-significant limb of the operation.
- `out_valid` out 1: a result limb is held.
- `out_ready` in 1: the consumer takes the result limb.
- `out_sum` out 32: result limb.
- `out_idx` out IDX_W: limb index within the operation (0 = LS limb).
- `out_last` out 1: this is the final limb.
- `out_cout` out 1: carry-out of the final limb; 0 when `out_last`=0.
- `out_ovf` out 1: signed overflow of the whole operation; 0 when `out_last`=0.

## Operation
- Accept occurs when `in_valid && in_ready`. `in_ready = !out_valid || out_ready`, which is combinational from `out_ready`.
- FSM states:
  - IDLE: no operation in progress. An accept moves to RUN unless `in_last`=1, in which case the state stays IDLE.
  - RUN: mid-operation. An accept with `in_last`=1 moves to IDLE.
- `op_sub` register: loaded from `in_sub` on the first-limb accept (state IDLE). It is held for the rest of the operation. The first limb uses `in_sub` directly.
- Effective operand: `b_eff = sub ? ~in_b : in_b`.
- Carry-in: `sub` on the first limb; otherwise `carry_q`.
- Sum: `{cout, sum} = in_a + b_eff + cin`, computed at full 33-bit width. `carry_q <= cout` on every accept.
- Overflow on the last limb: `ovf = (in_a[31] == b_eff[31]) && (sum[31] != in_a[31])`.
- For subtraction, `out_cout` = 1 means no borrow.
- Index counter: 0 on the first limb, then +1 per accept. It wraps modulo 2^IDX_W with no error. It resets to 0 after the last limb.
- No accept means no change to `carry_q`, the FSM, or the index.

## Timing
- Latency: a limb accepted at edge N appears on `out_*` with `out_valid`=1 after edge N.
- Throughput: 1 limb/cycle while `out_ready`=1.
- Output register: holds stable while `out_valid && !out_ready`.
- Simultaneous accept and take of the old result: the new limb replaces it in the same edge.
- `out_valid` falls only on an edge where `out_ready`=1 and no new accept occurs.
- Reset values (asynchronous, any cycle including mid-operation):
  - FSM = IDLE; `carry_q`, `op_sub`, index = 0.
  - `out_valid`, `out_sum`, `out_idx`, `out_last`, `out_cout`, `out_ovf` = 0.
  - A partially streamed operation is discarded. The next accepted limb is treated as a first limb.

## Configuration
- `MULTIWORD_ADD_SUB_EN`:
  - Defined: subtraction as specified.
  - Undefined: `in_sub` is ignored, `op_sub` is removed, `sub` is treated as constant 0, and the first-limb carry-in is 0. Ports are unchanged.

## Structure
- Package `multiword_add_pkg` holds:
  - `WORD_W` constant;
  - `state_e` enum {IDLE, RUN};
  - a packed `result_s` struct {sum, idx, last, cout, ovf} for the output register.
- Sub-module `add_word_slice`: a combinational 32-bit add with carry-in, returning sum, carry-out and signed overflow. The sequencer instantiates it once.

## Test plan
- 2-limb add: A=0xFFFFFFFF_FFFFFFFF, B=0x00000000_00000001, sub=0.
  - Expect limbs 0x00000000 (idx0), then 0x00000000 (idx1, last), cout=1, ovf=0.
- 2-limb subtract: A=0x00000001_00000000, B=1, sub=1.
  - Expect 0xFFFFFFFF, then 0x00000000, last, cout=1, ovf=0.
  - With the macro undefined: expect 0x00000001, then 0x00000001, cout=0.
- Single limb: A=0x7FFFFFFF, B=1, in_last=1.
  - Expect sum=0x80000000, idx=0, last=1, cout=0, ovf=1; FSM stays IDLE.
- Backpressure: 4-limb add with `out_ready`=0 for 3 cycles after the first result.
  - `in_ready`=0 during the stall and `out_sum` is stable.
  - No limb is lost or duplicated; idx sequence is 0,1,2,3.
- Reset mid-op: assert `rst` after limb 1 of a 3-limb add.
  - All outputs go to 0 immediately.
  - The next operation A=5, B=3 (single limb) yields 8 with carry-in 0.
- Index wrap (IDX_W=2): 5-limb operation of all-zero limbs.
  - Expect idx 0,1,2,3,0, with last only on the fifth limb.

Source files
------------

// File: rtl/multiword_add_pkg.sv
// Shared types for the multi-word add/subtract sequencer: word width, FSM states
// and the packed layout of the registered result limb.
package multiword_add_pkg;

  localparam int WORD_W    = 32;
  localparam int IDX_MAX_W = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // idx is stored at its widest supported size; the sequencer drives the low IDX_W bits.
  typedef struct packed {
    logic [WORD_W-1:0]    sum;
    logic [IDX_MAX_W-1:0] idx;
    logic                 last;
    logic                 cout;
    logic                 ovf;
  } result_s;

endpackage

// File: rtl/add_word_slice.sv
// Combinational 32-bit limb adder with carry-in.
// Returns the sum, the carry-out and the signed-overflow flag.
module add_word_slice
  import multiword_add_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout,
  output logic              ovf
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, cin};
  assign ovf = (a[WORD_W-1] == b[WORD_W-1]) && (sum[WORD_W-1] != a[WORD_W-1]);

endmodule

// File: rtl/multiword_add_sequencer.sv
// Streams multi-limb add/subtract operations LS limb first through one add_word_slice,
// chaining the carry across limbs. Subtraction is built only when MULTIWORD_ADD_SUB_EN is defined.
module multiword_add_sequencer
  import multiword_add_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  input  logic              in_sub,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_sum,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              out_cout,
  output logic              out_ovf
);

  if (WORD_W != 32) begin : g_bad_word_w
    $error("multiword_add_sequencer: WORD_W must be 32");
  end
  if (IDX_W > IDX_MAX_W || IDX_W < 1) begin : g_bad_idx_w
    $error("multiword_add_sequencer: IDX_W out of range");
  end

  state_e            state_r, state_d;
  logic              carry_r, carry_d;
  logic [IDX_W-1:0]  idx_r, idx_d;
  logic              out_valid_r, out_valid_d;
  result_s           res_r, res_d;

  logic              accept_s;
  logic              first_s;
  logic              sub_s;
  logic              cin_s;
  logic [WORD_W-1:0] b_eff_s;
  logic [WORD_W-1:0] slice_sum_s;
  logic              slice_cout_s;
  logic              slice_ovf_s;
  logic              idx_unused_s;

  assign in_ready = !out_valid_r || out_ready;
  assign accept_s = in_valid && in_ready;
  assign first_s  = (state_r == IDLE);

`ifdef MULTIWORD_ADD_SUB_EN
  logic op_sub_r, op_sub_d;

  // The first limb uses in_sub directly; later limbs reuse the latched mode.
  assign sub_s = first_s ? in_sub : op_sub_r;
`else
  logic sub_unused_s;

  assign sub_s        = 1'b0;
  assign sub_unused_s = in_sub;
`endif

  assign b_eff_s = sub_s ? ~in_b : in_b;
  assign cin_s   = first_s ? sub_s : carry_r;

  add_word_slice u_slice (
    .a    (in_a),
    .b    (b_eff_s),
    .cin  (cin_s),
    .sum  (slice_sum_s),
    .cout (slice_cout_s),
    .ovf  (slice_ovf_s)
  );

  // Next-state, carry chain, limb index and output-register load.
  always_comb begin
    state_d     = state_r;
    carry_d     = carry_r;
    idx_d       = idx_r;
    out_valid_d = out_valid_r;
    res_d       = res_r;
`ifdef MULTIWORD_ADD_SUB_EN
    op_sub_d    = op_sub_r;
`endif
    if (accept_s) begin
      carry_d     = slice_cout_s;
      idx_d       = in_last ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
      out_valid_d = 1'b1;
      res_d.sum   = slice_sum_s;
      res_d.idx   = IDX_MAX_W'(idx_r);
      res_d.last  = in_last;
      res_d.cout  = in_last & slice_cout_s;
      res_d.ovf   = in_last & slice_ovf_s;
      case (state_r)
        IDLE:    state_d = in_last ? IDLE : RUN;
        RUN:     state_d = in_last ? IDLE : RUN;
        default: state_d = IDLE;
      endcase
`ifdef MULTIWORD_ADD_SUB_EN
      if (first_s) begin
        op_sub_d = in_sub;
      end else begin
        op_sub_d = op_sub_r;
      end
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_r;
    end
  end

  // State, carry, index and output registers; reset discards any partial operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      carry_r     <= 1'b0;
      idx_r       <= {IDX_W{1'b0}};
      out_valid_r <= 1'b0;
      res_r       <= {$bits(result_s){1'b0}};
`ifdef MULTIWORD_ADD_SUB_EN
      op_sub_r    <= 1'b0;
`endif
    end else begin
      state_r     <= state_d;
      carry_r     <= carry_d;
      idx_r       <= idx_d;
      out_valid_r <= out_valid_d;
      res_r       <= res_d;
`ifdef MULTIWORD_ADD_SUB_EN
      op_sub_r    <= op_sub_d;
`endif
    end
  end

  assign out_valid    = out_valid_r;
  assign out_sum      = res_r.sum;
  assign out_idx      = res_r.idx[IDX_W-1:0];
  assign out_last     = res_r.last;
  assign out_cout     = res_r.cout;
  assign out_ovf      = res_r.ovf;
  assign idx_unused_s = ^res_r.idx;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed self-checking bench for multiword_add_sequencer: a default instance
// (IDX_W=4) plus an IDX_W=2 instance for the index-wrap case.
module tb_multiword_add_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid, in_ready, in_sub, in_last;
  logic [31:0] in_a, in_b;
  logic        out_valid, out_ready, out_last, out_cout, out_ovf;
  logic [31:0] out_sum;
  logic [3:0]  out_idx;

  logic        w_in_valid, w_in_ready, w_in_sub, w_in_last;
  logic [31:0] w_in_a, w_in_b;
  logic        w_out_valid, w_out_ready, w_out_last, w_out_cout, w_out_ovf;
  logic [31:0] w_out_sum;
  logic [1:0]  w_out_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multiword_add_sequencer #(.WORD_W(32), .IDX_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_sub(in_sub), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_idx(out_idx), .out_last(out_last), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  multiword_add_sequencer #(.WORD_W(32), .IDX_W(2)) dut_w (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_a(w_in_a), .in_b(w_in_b),
    .in_sub(w_in_sub), .in_last(w_in_last),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_sum(w_out_sum),
    .out_idx(w_out_idx), .out_last(w_out_last), .out_cout(w_out_cout), .out_ovf(w_out_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] sum,
                            input logic [3:0] idx, input logic last, input logic cout,
                            input logic ovf);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".sum"},   out_sum, sum);
    chk({tag, ".idx"},   {28'd0, out_idx}, {28'd0, idx});
    chk({tag, ".last"},  {31'd0, out_last}, {31'd0, last});
    chk({tag, ".cout"},  {31'd0, out_cout}, {31'd0, cout});
    chk({tag, ".ovf"},   {31'd0, out_ovf}, {31'd0, ovf});
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic last);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_last  = last;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_a     = 32'd0;
    in_b     = 32'd0;
    in_sub   = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    idle();
    out_ready   = 1'b1;
    w_in_valid  = 1'b0;
    w_in_a      = 32'd0;
    w_in_b      = 32'd0;
    w_in_sub    = 1'b0;
    w_in_last   = 1'b0;
    w_out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    expect_out("reset", 1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // 2-limb add: FFFFFFFF_FFFFFFFF + 1
    put(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("add2.l0", 1'b1, 32'h0000_0000, 4'd0, 1'b0, 1'b0, 1'b0);
    put(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
    @(negedge clk);
    expect_out("add2.l1", 1'b1, 32'h0000_0000, 4'd1, 1'b1, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    chk("add2.drain", {31'd0, out_valid}, 32'd0);

    // 2-limb subtract: 00000001_00000000 - 1 (in_sub low on limb 1)
    put(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0);
    @(negedge clk);
`ifdef MULTIWORD_ADD_SUB_EN
    expect_out("sub2.l0", 1'b1, 32'hFFFF_FFFF, 4'd0, 1'b0, 1'b0, 1'b0);
`else
    expect_out("sub2.l0", 1'b1, 32'h0000_0001, 4'd0, 1'b0, 1'b0, 1'b0);
`endif
    put(32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1);
    @(negedge clk);
`ifdef MULTIWORD_ADD_SUB_EN
    expect_out("sub2.l1", 1'b1, 32'h0000_0000, 4'd1, 1'b1, 1'b1, 1'b0);
`else
    expect_out("sub2.l1", 1'b1, 32'h0000_0001, 4'd1, 1'b1, 1'b0, 1'b0);
`endif
    idle();
    @(negedge clk);

    // Single limb with signed overflow, then another single limb (FSM must be IDLE)
    put(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    @(negedge clk);
    expect_out("single.ovf", 1'b1, 32'h8000_0000, 4'd0, 1'b1, 1'b0, 1'b1);
    put(32'h0000_0002, 32'h0000_0002, 1'b0, 1'b1);
    @(negedge clk);
    expect_out("single.next", 1'b1, 32'h0000_0004, 4'd0, 1'b1, 1'b0, 1'b0);
    idle();
    @(negedge clk);

    // Backpressure: 4-limb add, out_ready low for 3 cycles after first result
    put(32'h0000_0001, 32'h0000_0010, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("bp.l0", 1'b1, 32'h0000_0011, 4'd0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    put(32'h0000_0002, 32'h0000_0020, 1'b0, 1'b0);
    #1;
    chk("bp.in_ready_low", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp.stall.sum", out_sum, 32'h0000_0011);
      chk("bp.stall.idx", {28'd0, out_idx}, 32'd0);
      chk("bp.stall.valid", {31'd0, out_valid}, 32'd1);
      chk("bp.stall.in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    expect_out("bp.l1", 1'b1, 32'h0000_0022, 4'd1, 1'b0, 1'b0, 1'b0);
    put(32'h0000_0003, 32'h0000_0030, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("bp.l2", 1'b1, 32'h0000_0033, 4'd2, 1'b0, 1'b0, 1'b0);
    put(32'h0000_0004, 32'h0000_0040, 1'b0, 1'b1);
    @(negedge clk);
    expect_out("bp.l3", 1'b1, 32'h0000_0044, 4'd3, 1'b1, 1'b0, 1'b0);
    idle();
    @(negedge clk);

    // Reset mid-operation: two limbs of a 3-limb add leave carry_q=1 in RUN
    put(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("rstop.l0", 1'b1, 32'h0000_0000, 4'd0, 1'b0, 1'b0, 1'b0);
    put(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("rstop.l1", 1'b1, 32'h0000_0000, 4'd1, 1'b0, 1'b0, 1'b0);
    idle();
    #2;
    rst = 1'b1;
    #1;
    expect_out("rstop.async", 1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    put(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1);
    @(negedge clk);
    expect_out("rstop.next", 1'b1, 32'h0000_0008, 4'd0, 1'b1, 1'b0, 1'b0);
    idle();
    @(negedge clk);

    // Index wrap on the IDX_W=2 instance: 5 all-zero limbs
    for (int i = 0; i < 5; i++) begin
      w_in_valid = 1'b1;
      w_in_last  = (i == 4);
      @(negedge clk);
      chk("wrap.valid", {31'd0, w_out_valid}, 32'd1);
      chk("wrap.idx",   {30'd0, w_out_idx}, i % 4);
      chk("wrap.last",  {31'd0, w_out_last}, (i == 4) ? 32'd1 : 32'd0);
      chk("wrap.sum",   w_out_sum, 32'd0);
    end
    w_in_valid = 1'b0;
    w_in_last  = 1'b0;
    @(negedge clk);
    chk("wrap.drain", {31'd0, w_out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
